// File: rtl/fc_argmax_if.sv
// fc_argmax_if: handshake and result bundle for fc_argmax.
// Runner-up fields exist only when FC_ARGMAX_TOP2_EN is defined.
interface fc_argmax_if #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W = 54,
  parameter int IDX_W = $clog2(NUM_CLASSES)
) ();
  logic                     valid_in;
  logic signed [DATA_W-1:0] fc_in [NUM_CLASSES];
  logic                     in_ready;
  logic [IDX_W-1:0]         class_out;
  logic signed [DATA_W-1:0] max_out;
  logic                     valid_out;
  logic                     ready_in;
  logic                     busy;
  logic                     drop_err;
`ifdef FC_ARGMAX_TOP2_EN
  logic [IDX_W-1:0]         second_out;
  logic signed [DATA_W:0]   margin_out;

  modport master (
    output valid_in, fc_in, ready_in,
    input  in_ready, class_out, max_out,
    input  valid_out, busy, drop_err,
    input  second_out, margin_out
  );
  modport slave (
    input  valid_in, fc_in, ready_in,
    output in_ready, class_out, max_out,
    output valid_out, busy, drop_err,
    output second_out, margin_out
  );
`else
  modport master (
    output valid_in, fc_in, ready_in,
    input  in_ready, class_out, max_out,
    input  valid_out, busy, drop_err
  );
  modport slave (
    input  valid_in, fc_in, ready_in,
    output in_ready, class_out, max_out,
    output valid_out, busy, drop_err
  );
`endif
endinterface

// File: rtl/fc_argmax.sv
// fc_argmax: sequential argmax over the FC layer outputs.
// Define FC_ARGMAX_TOP2_EN to also track runner-up and margin.
module fc_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W = 54,
  parameter int IDX_W = $clog2(NUM_CLASSES)
) (
  input logic        clk,
  input logic        rst_n,
  fc_argmax_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic signed [DATA_W-1:0] data_q [NUM_CLASSES];
  logic signed [DATA_W-1:0] best;
  logic signed [DATA_W-1:0] best_nx;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] max_q;
  logic [IDX_W-1:0]         best_idx;
  logic [IDX_W-1:0]         best_idx_nx;
  logic [IDX_W-1:0]         class_q;
  logic [IDX_W-1:0]         cnt;
  logic                     accept;
  logic                     last;
  logic                     gt;
  logic                     drop_q;

  assign accept = bus.valid_in && (state == IDLE);
  assign last = cnt == IDX_W'(NUM_CLASSES - 1);
  assign x = data_q[cnt];
  assign gt = x > best;
  assign best_nx = gt ? x : best;
  assign best_idx_nx = gt ? cnt : best_idx;

  assign bus.in_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.valid_out = state == DONE;
  assign bus.class_out = class_q;
  assign bus.max_out = max_q;
  assign bus.drop_err = drop_q;

`ifdef FC_ARGMAX_TOP2_EN
  logic signed [DATA_W-1:0] second;
  logic signed [DATA_W-1:0] second_nx;
  logic [IDX_W-1:0]         second_idx;
  logic [IDX_W-1:0]         second_idx_nx;
  logic [IDX_W-1:0]         second_q;
  logic signed [DATA_W:0]   margin_q;
  logic signed [DATA_W:0]   margin_nx;

  // Runner-up update: a new best demotes the old one.
  always_comb begin
    second_nx = second;
    second_idx_nx = second_idx;
    if (gt) begin
      second_nx = best;
      second_idx_nx = best_idx;
    end else if (x > second) begin
      second_nx = x;
      second_idx_nx = cnt;
    end
  end

  assign margin_nx = $signed({best_nx[DATA_W-1], best_nx})
                   - $signed({second_nx[DATA_W-1], second_nx});
  assign bus.second_out = second_q;
  assign bus.margin_out = margin_q;

  // Runner-up tracking and registered top-2 results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second <= '0;
      second_idx <= '0;
      second_q <= '0;
      margin_q <= '0;
    end else if (accept) begin
      second <= {1'b1, {(DATA_W-1){1'b0}}};
      second_idx <= '0;
    end else if (state == SCAN) begin
      second <= second_nx;
      second_idx <= second_idx_nx;
      if (last) begin
        second_q <= second_idx_nx;
        margin_q <= margin_nx;
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.valid_in) state_nx = SCAN;
      SCAN: if (last) state_nx = DONE;
      DONE: if (bus.ready_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture on accept, then one class compared per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) data_q[i] <= '0;
      best <= '0;
      best_idx <= '0;
      cnt <= '0;
      class_q <= '0;
      max_q <= '0;
    end else if (accept) begin
      data_q <= bus.fc_in;
      best <= bus.fc_in[0];
      best_idx <= '0;
      cnt <= IDX_W'(1);
    end else if (state == SCAN) begin
      best <= best_nx;
      best_idx <= best_idx_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        class_q <= best_idx_nx;
        max_q <= best_nx;
      end
    end
  end

  // Sticky flag for inputs offered while not idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= 1'b0;
    else if (bus.valid_in && state != IDLE) drop_q <= 1'b1;
  end
endmodule

// File: tb/tb_fc_argmax.sv
// tb_fc_argmax: scoreboard bench for fc_argmax.
// Top-2 checks follow FC_ARGMAX_TOP2_EN.
module tb_fc_argmax;
  localparam int N = 10;
  localparam int W = 54;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fc_argmax_if #(.NUM_CLASSES(N), .DATA_W(W), .IDX_W(IW)) bus ();

  fc_argmax #(.NUM_CLASSES(N), .DATA_W(W), .IDX_W(IW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [IW-1:0]       idx;
    logic signed [W-1:0] mx;
    logic [IW-1:0]       sidx;
    logic signed [W:0]   mg;
  } exp_t;

  exp_t sb[$];
  logic signed [W-1:0] vec [N];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    int b = 0;
    int s = -1;
    for (int i = 1; i < N; i++)
      if (vec[i] > vec[b]) b = i;
    for (int i = 0; i < N; i++)
      if (i != b && (s < 0 || vec[i] > vec[s])) s = i;
    e.idx = IW'(b);
    e.mx = vec[b];
    e.sidx = IW'(s);
    e.mg = $signed({vec[b][W-1], vec[b]})
         - $signed({vec[s][W-1], vec[s]});
    return e;
  endfunction

  task automatic clr();
    for (int i = 0; i < N; i++) vec[i] = '0;
  endtask

  task automatic send();
    @(negedge clk);
    check_eq("in_ready_pre", bus.in_ready, 1);
    bus.fc_in = vec;
    bus.valid_in = 1'b1;
    sb.push_back(model());
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
    for (int i = 0; i < N; i++)
      bus.fc_in[i] = W'({$urandom, $urandom});
    check_eq("in_ready_busy", bus.in_ready, 0);
    check_eq("busy_scan", bus.busy, 1);
  endtask

  task automatic collect();
    exp_t e;
    int lat = 0;
    while (!bus.valid_out && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", lat, N - 1);
    check_eq("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("class_out", bus.class_out, e.idx);
      check_eq("max_out", bus.max_out, e.mx);
`ifdef FC_ARGMAX_TOP2_EN
      check_eq("second_out", bus.second_out, e.sidx);
      check_eq("margin_out", bus.margin_out, e.mg);
`endif
    end
  endtask

  task automatic handshake();
    bus.ready_in = 1'b1;
    @(negedge clk);
    check_eq("valid_clr", bus.valid_out, 0);
    check_eq("in_ready_back", bus.in_ready, 1);
  endtask

  task automatic run_one();
    send();
    collect();
    handshake();
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_in_ready"}, bus.in_ready, 1);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_drop"}, bus.drop_err, 0);
    check_eq({tag, "_valid"}, bus.valid_out, 0);
    check_eq({tag, "_class"}, bus.class_out, 0);
    check_eq({tag, "_max"}, bus.max_out, 0);
`ifdef FC_ARGMAX_TOP2_EN
    check_eq({tag, "_second"}, bus.second_out, 0);
    check_eq({tag, "_margin"}, bus.margin_out, 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] c_hold;
    logic signed [W-1:0] m_hold;
    bit stable;

    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    for (int i = 0; i < N; i++) bus.fc_in[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("rst");

    clr();
    vec[0] = -54'sd5;
    vec[3] = 54'sd1000;
    run_one();

    for (int i = 0; i < N; i++) vec[i] = W'(-100 + i);
    run_one();

    clr();
    vec[2][52] = 1'b1;
    vec[7][52] = 1'b1;
    run_one();

    clr();
    vec[0] = {1'b1, {(W-1){1'b0}}};
    vec[5] = {1'b0, {(W-1){1'b1}}};
    run_one();

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++)
        vec[i] = (t == 0) ? W'({$urandom, $urandom})
                          : W'($urandom_range(0, 7)) - 54'sd4;
      run_one();
    end

    clr();
    vec[4] = 54'sd77;
    vec[8] = -54'sd3;
    bus.ready_in = 1'b0;
    send();
    collect();
    c_hold = bus.class_out;
    m_hold = bus.max_out;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.valid_in = (k == 5);
      if (!bus.valid_out || bus.class_out != c_hold ||
          bus.max_out != m_hold)
        stable = 1'b0;
    end
    bus.valid_in = 1'b0;
    check_eq("stall_stable", stable, 1);
    check_eq("drop_err_set", bus.drop_err, 1);
    handshake();
    check_eq("drop_err_sticky", bus.drop_err, 1);

    clr();
    vec[6] = 54'sd9;
    send();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("midscan");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    clr();
    vec[1] = 54'sd12345;
    vec[9] = 54'sd12344;
    run_one();
    check_eq("drop_after_rst", bus.drop_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
